// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline hazard types and constants
package pipe_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use dependency match
import pipe_pkg::*;

module hazard_detect (
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_is_load,
    output logic             o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign o_load_use = i_ex_is_load && i_ex_reg_write && (i_ex_rd != ZERO_REG)
                        && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - freeze/flush controller for the 5-stage pipeline
import pipe_pkg::*;

module hazard_ctrl #(
    parameter int MUL_LAT  = 4,
    parameter int STALL_CW = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [REG_W-1:0]    i_id_rs1,
    input  logic [REG_W-1:0]    i_id_rs2,
    input  logic                i_id_use_rs1,
    input  logic                i_id_use_rs2,
    input  logic                i_id_is_mul,
    input  logic [REG_W-1:0]    i_ex_rd,
    input  logic                i_ex_reg_write,
    input  logic                i_ex_is_load,
    input  logic                i_ex_branch_taken,
    input  logic                i_mem_req,
    input  logic                i_mem_ready,
    output logic                o_pc_freeze,
    output logic                o_if2id_freeze,
    output logic                o_id2ex_freeze,
    output logic                o_ex2mem_freeze,
    output logic                o_if2id_flush,
    output logic                o_id2ex_flush,
    output logic                o_ex2mem_flush,
    output logic                o_mem2wb_flush,
    output logic                o_busy_mul,
    output logic [STALL_CW-1:0] o_stall_cycles
);

    localparam int CNT_W = $clog2(MUL_LAT) + 1;
    localparam logic MUL_EN = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_mul_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [STALL_CW-1:0] r_stall;
    logic                w_load_use;
    logic                w_mem_wait;

    hazard_detect u_detect (
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_use_rs1   (i_id_use_rs1),
        .i_id_use_rs2   (i_id_use_rs2),
        .i_ex_rd        (i_ex_rd),
        .i_ex_reg_write (i_ex_reg_write),
        .i_ex_is_load   (i_ex_is_load),
        .o_load_use     (w_load_use)
    );

    assign w_mem_wait     = i_mem_req && !i_mem_ready;
    assign o_busy_mul     = (r_state == ST_MUL);
    assign o_stall_cycles = r_stall;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_mul_cnt;
        o_pc_freeze     = 1'b0;
        o_if2id_freeze  = 1'b0;
        o_id2ex_freeze  = 1'b0;
        o_ex2mem_freeze = 1'b0;
        o_if2id_flush   = 1'b0;
        o_id2ex_flush   = 1'b0;
        o_ex2mem_flush  = 1'b0;
        o_mem2wb_flush  = 1'b0;
        if (w_mem_wait) begin
            o_pc_freeze     = 1'b1;
            o_if2id_freeze  = 1'b1;
            o_id2ex_freeze  = 1'b1;
            o_ex2mem_freeze = 1'b1;
            o_mem2wb_flush  = 1'b1;
        end else if (r_state == ST_MUL) begin
            o_pc_freeze    = 1'b1;
            o_if2id_freeze = 1'b1;
            o_id2ex_freeze = 1'b1;
            o_ex2mem_flush = 1'b1;
            w_cnt_nxt      = r_mul_cnt - CNT_ONE;
            if (r_mul_cnt == CNT_ONE) begin
                w_state_nxt = ST_RUN;
            end
        end else if (i_ex_branch_taken) begin
            o_if2id_flush = 1'b1;
            o_id2ex_flush = 1'b1;
        end else if (w_load_use) begin
            o_pc_freeze    = 1'b1;
            o_if2id_freeze = 1'b1;
            o_id2ex_flush  = 1'b1;
        end else if (i_id_is_mul && MUL_EN) begin
            w_state_nxt = ST_MUL;
            w_cnt_nxt   = CNT_LOAD;
        end
        // reset masks every hazard response so the pipeline registers load cleanly
        if (!i_rst) begin
            o_pc_freeze     = 1'b0;
            o_if2id_freeze  = 1'b0;
            o_id2ex_freeze  = 1'b0;
            o_ex2mem_freeze = 1'b0;
            o_if2id_flush   = 1'b0;
            o_id2ex_flush   = 1'b0;
            o_ex2mem_flush  = 1'b0;
            o_mem2wb_flush  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_RUN;
            r_mul_cnt <= '0;
            r_stall   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_cnt_nxt;
            if (o_pc_freeze && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_is_mul;
    logic       ex_reg_write, ex_is_load, ex_branch_taken;
    logic       mem_req, mem_ready;

    logic [8:0]  a_out, b_out;
    logic [3:0]  a_stall;
    logic [15:0] b_stall;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .STALL_CW(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2), .i_id_is_mul(id_is_mul),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_is_load(ex_is_load),
        .i_ex_branch_taken(ex_branch_taken), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_freeze(a_out[8]), .o_if2id_freeze(a_out[7]), .o_id2ex_freeze(a_out[6]),
        .o_ex2mem_freeze(a_out[5]), .o_if2id_flush(a_out[4]), .o_id2ex_flush(a_out[3]),
        .o_ex2mem_flush(a_out[2]), .o_mem2wb_flush(a_out[1]), .o_busy_mul(a_out[0]),
        .o_stall_cycles(a_stall)
    );

    hazard_ctrl #(.MUL_LAT(1), .STALL_CW(16)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2), .i_id_is_mul(id_is_mul),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_is_load(ex_is_load),
        .i_ex_branch_taken(ex_branch_taken), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_freeze(b_out[8]), .o_if2id_freeze(b_out[7]), .o_id2ex_freeze(b_out[6]),
        .o_ex2mem_freeze(b_out[5]), .o_if2id_flush(b_out[4]), .o_id2ex_flush(b_out[3]),
        .o_ex2mem_flush(b_out[2]), .o_mem2wb_flush(b_out[1]), .o_busy_mul(b_out[0]),
        .o_stall_cycles(b_stall)
    );

    typedef struct {
        logic [8:0] a_out;
        int         a_stall;
        logic [8:0] b_out;
        int         b_stall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // model: remaining multiply stall cycles and stall count per instance
    int lat[2]   = '{4, 1};
    int smax[2]  = '{15, 65535};
    int m_rem[2] = '{0, 0};
    int m_stl[2] = '{0, 0};

    function automatic bit load_use();
        return ex_is_load && ex_reg_write && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [8:0] expect_out(input int d);
        logic [8:0] v;
        v = 9'b0;
        if (!rst)                          v = 9'b0;
        else if (mem_req && !mem_ready)    v = 9'b1111_0001_0;
        else if (m_rem[d] > 0)             v = 9'b1110_0010_0;
        else if (ex_branch_taken)          v = 9'b0000_1100_0;
        else if (load_use())               v = 9'b1100_0100_0;
        v[0] = (m_rem[d] > 0);
        return v;
    endfunction

    task automatic advance(input int d, input logic [8:0] v);
        if (!rst) begin
            m_rem[d] = 0;
            m_stl[d] = 0;
        end else begin
            if (v[8] && m_stl[d] < smax[d]) m_stl[d]++;
            if (mem_req && !mem_ready) ;
            else if (m_rem[d] > 0) m_rem[d]--;
            else if (!ex_branch_taken && !load_use() && id_is_mul && lat[d] > 1)
                m_rem[d] = lat[d] - 1;
        end
    endtask

    task automatic step();
        exp_t e;
        e.a_out   = expect_out(0);
        e.b_out   = expect_out(1);
        e.a_stall = m_stl[0];
        e.b_stall = m_stl[1];
        sb.push_back(e);
        advance(0, e.a_out);
        advance(1, e.b_out);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_is_mul = 0;
        ex_reg_write = 0; ex_is_load = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("a_outputs", int'(a_out), int'(e.a_out));
            chk("a_stall", int'(a_stall), e.a_stall);
            chk("b_outputs", int'(b_out), int'(e.b_out));
            chk("b_stall", int'(b_stall), e.b_stall);
        end
    end

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();
        idle(); step();
        // load-use on rs2, then the same with x0 as destination
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; step();
        idle(); step();
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1; step();
        // branch wins over load-use
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        ex_branch_taken = 1; step();
        idle(); id_is_mul = 1; step();
        idle(); repeat (4) step();
        // memory wait inside a multiply
        id_is_mul = 1; step();
        idle(); step();
        mem_req = 1; mem_ready = 0; step(); step();
        mem_ready = 1; step();
        idle(); repeat (4) step();
        // reset mid-multiply
        id_is_mul = 1; step();
        idle(); step();
        rst = 0; step();
        idle(); repeat (2) step();
        // saturation of the 4-bit counter
        mem_req = 1; mem_ready = 0; repeat (20) step();
        idle(); step();
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 39) != 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom);
            id_use_rs2      = 1'($urandom);
            id_is_mul       = ($urandom_range(0, 3) == 0);
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_is_load      = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = 1'($urandom);
            step();
        end
        idle();
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
